// File: rtl/blur_pkg.sv
// blur_pkg: shared geometry, mode/state types and kernel delay helpers for the blur controller
package blur_pkg;
  localparam int IMAGE_WIDTH = 320;
  localparam int IMAGE_HEIGHT = 240;
  localparam int PIPE_LAT = 4;
  localparam int CNT_W = 17;
  typedef enum logic [1:0] {BLUR_1X1 = 2'd0, BLUR_3X3 = 2'd1, BLUR_5X5 = 2'd2} blur_mode_t;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;
  // shifts from a pixel entering the line buffer until its filtered value leaves the pipeline
  function automatic logic [CNT_W-1:0] blur_delay(input blur_mode_t m, input int width = IMAGE_WIDTH,
                                                  input int pipe_lat = PIPE_LAT);
    return (m == BLUR_1X1) ? CNT_W'(1) : CNT_W'(int'(m) * (width + 1) + pipe_lat);
  endfunction
  function automatic blur_mode_t to_mode(input logic [2:0] f);
    return (f == 3'd1) ? BLUR_3X3 : (f == 3'd2) ? BLUR_5X5 : BLUR_1X1;
  endfunction
endpackage

// File: rtl/blur_xy_counter.sv
// blur_xy_counter: raster x/y position counter; clear wins, then an enable steps from the cleared value
module blur_xy_counter #(
  parameter int WIDTH = 320,
  parameter int HEIGHT = 240,
  parameter int XW = 9,
  parameter int YW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en_i,
  input  logic          clr_i,
  output logic [XW-1:0] x_o,
  output logic [YW-1:0] y_o
);
  logic [XW-1:0] x_q, x_b, x_d;
  logic [YW-1:0] y_q, y_b, y_d;
  logic x_wrap;
  always_comb begin
    x_b = clr_i ? '0 : x_q;
    y_b = clr_i ? '0 : y_q;
    x_wrap = int'(x_b) == WIDTH - 1;
    x_d = en_i ? (x_wrap ? '0 : x_b + XW'(1)) : x_b;
    y_d = (en_i && x_wrap) ? ((int'(y_b) == HEIGHT - 1) ? '0 : y_b + YW'(1)) : y_b;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  assign x_o = x_q;
  assign y_o = y_q;
endmodule

// File: rtl/blur_stream_controller.sv
// blur_stream_controller: frame sequencer for the RGB444 blur datapath; gates the filter shift,
// injects zero flush pixels after end-of-frame and regenerates aligned output framing.
module blur_stream_controller #(
  parameter int IMAGE_WIDTH = blur_pkg::IMAGE_WIDTH,
  parameter int IMAGE_HEIGHT = blur_pkg::IMAGE_HEIGHT,
  parameter int PIPE_LAT = blur_pkg::PIPE_LAT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] freq_flag,
  input  logic       valid_in,
  input  logic       startofpacket_in,
  input  logic       endofpacket_in,
  output logic       ready_out,
  input  logic       ready_in,
  output logic       valid_out,
  output logic       startofpacket_out,
  output logic       endofpacket_out,
  output logic [1:0] mode,
  output logic       shift_en,
  output logic       flush,
  output logic       border_mask,
  output logic       frame_err
);
  import blur_pkg::*;
  localparam logic [CNT_W-1:0] N = CNT_W'(IMAGE_WIDTH * IMAGE_HEIGHT);
  state_t state_q, state_d;
  blur_mode_t mode_q, mode_d;
  logic [CNT_W-1:0] in_cnt_q, in_cnt_d, sh_cnt_q, sh_cnt_d, out_cnt_q, out_cnt_d;
  logic [CNT_W-1:0] in_b, sh_b, out_b, in_nx, fin, dly;
  logic valid_q, valid_d, sop_q, sop_d, eop_q, eop_d, bord_q, bord_d, err_q, err_d;
  logic can_adv, accept, sop_beat, eop_beat, restart, shift, draining, produce, bord;
  logic [8:0] out_x, x_b;
  logic [7:0] out_y, y_b;
  int r;
  // sh_cnt counts every shift incl. flushes, so kernel latency holds even for frames shorter than D
  always_comb begin
    draining = state_q == DRAIN;
    can_adv = !valid_q | ready_in;
    accept = valid_q & ready_in;
    sop_beat = valid_in & startofpacket_in;
    shift = !reset & ((state_q == IDLE) ? sop_beat :
                      (state_q == RUN) ? valid_in & can_adv : draining & can_adv);
    restart = shift & !draining & sop_beat;
    eop_beat = shift & !draining & endofpacket_in;
    mode_d = restart ? to_mode(freq_flag) : mode_q;
    r = int'(mode_d);
    dly = blur_delay(mode_d, IMAGE_WIDTH, PIPE_LAT);
    in_b = restart ? '0 : in_cnt_q;
    sh_b = restart ? '0 : sh_cnt_q;
    out_b = restart ? '0 : out_cnt_q;
    x_b = restart ? '0 : out_x;
    y_b = restart ? '0 : out_y;
    in_nx = draining ? in_cnt_q : in_b + CNT_W'(1);
    in_cnt_d = shift ? in_nx : in_cnt_q;
    sh_cnt_d = shift ? sh_b + CNT_W'(1) : sh_cnt_q;
    produce = shift & (sh_cnt_d >= dly) & (out_b < in_nx);
    fin = (eop_beat | draining) ? in_nx : N;
    out_cnt_d = produce ? out_b + CNT_W'(1) : out_b;
    bord = int'(x_b) < r || int'(x_b) >= IMAGE_WIDTH - r || int'(y_b) < r || int'(y_b) >= IMAGE_HEIGHT - r;
    valid_d = produce | (valid_q & !accept);
    sop_d = produce ? out_b == '0 : sop_q & !accept;
    eop_d = produce ? out_b == fin - CNT_W'(1) : eop_q & !accept;
    bord_d = produce ? bord : bord_q & !accept;
    err_d = shift & !draining & ((eop_beat & (in_nx < N)) | (state_q == RUN & sop_beat));
    state_d = (shift & !draining) ? ((eop_beat | in_nx == N) ? DRAIN : RUN) :
              (shift & draining & out_cnt_q == in_cnt_q) ? IDLE : state_q;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      mode_q <= BLUR_1X1;
      in_cnt_q <= '0;
      sh_cnt_q <= '0;
      out_cnt_q <= '0;
      valid_q <= 1'b0;
      sop_q <= 1'b0;
      eop_q <= 1'b0;
      bord_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q <= mode_d;
      in_cnt_q <= in_cnt_d;
      sh_cnt_q <= sh_cnt_d;
      out_cnt_q <= out_cnt_d;
      valid_q <= valid_d;
      sop_q <= sop_d;
      eop_q <= eop_d;
      bord_q <= bord_d;
      err_q <= err_d;
    end
  blur_xy_counter #(.WIDTH(IMAGE_WIDTH), .HEIGHT(IMAGE_HEIGHT), .XW(9), .YW(8)) u_xy (
    .clk(clk), .rst(reset), .en_i(produce), .clr_i(restart), .x_o(out_x), .y_o(out_y)
  );
  assign ready_out = !reset & ((state_q == IDLE) | ((state_q == RUN) & can_adv));
  assign shift_en = shift;
  assign flush = shift & draining;
  assign valid_out = valid_q;
  assign startofpacket_out = sop_q;
  assign endofpacket_out = eop_q;
  assign border_mask = bord_q;
  assign frame_err = err_q;
  assign mode = mode_q;
endmodule

// File: doc/blur_stream_controller.md
Name: blur_stream_controller

Overview:
- Frame-level sequencer for the 320x240 RGB444 blurring filter datapath, placed between the camera Avalon-ST source and the VGA sink.
- Latches the blur mode only at frame start and gates the filter line buffer and pipeline with one shift enable.
- Injects zero flush pixels after end-of-frame to drain the kernel delay.
- Regenerates valid/sop/eop aligned to the filter output and flags border pixels for zeroing.

Parameters:
- IMAGE_WIDTH, 320, pixels per line
- IMAGE_HEIGHT, 240, lines per frame
- PIPE_LAT, 4, filter arithmetic pipeline stages after the line buffer

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous active-high reset
- freq_flag  in  3  requested mode: 0 passthrough, 1 3x3, 2 5x5, others = 0
- valid_in  in  1  upstream pixel valid
- startofpacket_in  in  1  upstream first pixel of frame
- endofpacket_in  in  1  upstream last pixel of frame
- ready_out  out  1  upstream ready
- ready_in  in  1  downstream ready
- valid_out  out  1  filter output pixel valid
- startofpacket_out  out  1  first output pixel
- endofpacket_out  out  1  last output pixel
- mode  out  2  frame-stable mode to the filter
- shift_en  out  1  advance line buffer and pipeline one pixel
- flush  out  1  filter writes 0 instead of data_in this shift
- border_mask  out  1  filter forces data_out = 0 for this output pixel
- frame_err  out  1  one-cycle pulse: SOP mid-frame or early EOP

Behaviour:
- Reset: state IDLE; all outputs 0; mode 0; counters 0.
- Radius r = mode (0, 1 or 2). Delay D = 1 for mode 0, else r*IMAGE_WIDTH + r + PIPE_LAT. D = 325 for 3x3 and 646 for 5x5.
- N = IMAGE_WIDTH*IMAGE_HEIGHT = 76800. Counters: in_cnt and out_cnt are 17 bits; out_x is 9 bits; out_y is 8 bits.
- Output stage is a standard pipeline register. accept_out = valid_out & ready_in. can_adv = !valid_out | ready_in.
- IDLE:
  - ready_out = 1.
  - A non-SOP beat is discarded.
  - An SOP beat latches mode from freq_flag, sets in_cnt = 1, asserts shift_en, then goes to RUN.
- RUN:
  - ready_out = can_adv.
  - shift_en = valid_in & can_adv; in_cnt increments on each shift_en.
  - A shift with in_cnt >= D produces an output pixel.
  - An EOP beat, or reaching in_cnt = N, goes to DRAIN on that same shift.
- DRAIN:
  - ready_out = 0.
  - shift_en = can_adv and flush = shift_en. This continues until out_cnt reaches in_cnt, then go to IDLE.
  - In mode 0, DRAIN completes after one flush shift.
- Output production (registered on the producing shift):
  - valid_out = 1.
  - startofpacket_out = (out_cnt == 0).
  - endofpacket_out = (out_cnt == final count - 1), where final count = N, or in_cnt on early EOP.
  - border_mask = out_x < r | out_x >= IMAGE_WIDTH - r | out_y < r | out_y >= IMAGE_HEIGHT - r.
  - out_cnt increments; out_x wraps at IMAGE_WIDTH and then increments out_y.
- A shift that produces no output while accept_out fires clears valid_out. When ready_in = 0 and valid_out = 1, shift_en = 0 and all output registers hold.
- SOP in RUN (mid-frame):
  - Pulse frame_err and restart as in IDLE: relatch mode, in_cnt = 1, out counters = 0.
  - No EOP is emitted for the aborted frame.
- Early EOP (in_cnt < N): pulse frame_err. DRAIN emits exactly in_cnt outputs, and the last one carries endofpacket_out.
- Beats after in_cnt = N without EOP are dropped in IDLE.
- Changes to freq_flag mid-frame are ignored; mode changes only on an accepted SOP.
- Simultaneous SOP and EOP on one beat: 1-pixel frame. Go straight to DRAIN and raise frame_err.
- Reset mid-frame returns to IDLE immediately. Partial output is abandoned, with no EOP.

Decomposition:
- Package blur_pkg:
  - IMAGE_WIDTH, IMAGE_HEIGHT, PIPE_LAT
  - blur_mode_t enum {BLUR_1X1, BLUR_3X3, BLUR_5X5}
  - state enum {IDLE, RUN, DRAIN}
  - function blur_delay(mode) returning D
  - function to_mode(freq_flag) that saturates illegal values to BLUR_1X1
- Sub-module blur_xy_counter: enable, clear, x/y outputs, wrap at parameterised width and height. Used for the output coordinates.

Test Plan:
- Mode 2, full 76800-beat frame, ready_in = 1:
  - First valid_out arrives 646 shifts after the SOP beat, with startofpacket_out.
  - Exactly 76800 valid_out beats; endofpacket_out on the last one.
  - border_mask is 1 for output x in {0, 1, 318, 319} or y in {0, 1, 238, 239}.
- Mode 1 frame, ready_in toggled 1-0 every cycle:
  - valid_out, startofpacket_out and border_mask hold while stalled.
  - No beat is lost or duplicated; output total is 76800 and DRAIN issues 325 flush shifts.
- freq_flag changes from 2 to 1 at pixel 1000:
  - mode stays 2 for the frame.
  - The next SOP latches 1, and the first output follows after 325 shifts.
- SOP reasserted at in_cnt = 5000 in mode 1:
  - frame_err pulses once and the counters restart.
  - The next output carries startofpacket_out, and the full new frame yields 76800 beats.
- Mode 0, EOP at in_cnt = 100:
  - frame_err pulses.
  - 100 outputs with one-cycle latency, endofpacket_out on the 100th, then return to IDLE.
- Reset asserted mid-DRAIN:
  - All outputs go to 0 asynchronously and the state is IDLE.
  - The following SOP frame behaves as the first scenario.
